// File: rtl/state_if.sv
// state_if: elevator controller call/door bus.
//   sw    : floor call switches (bit i = call for floor i)
//   close : door-close request
//   floor : current cabin floor from the position counter
//   dir   : travel direction (1 = up, 0 = down)
//   door  : door state (1 = open)
interface state_if;
    logic [7:0] sw;
    logic       close;
    logic [2:0] floor;
    logic       dir;
    logic       door;

    modport master (output sw, close, floor, input dir, door);
    modport slave  (input sw, close, floor, output dir, door);
endinterface

// File: rtl/state.sv
// state: eight-floor elevator controller with pending-call register and door dwell timer.
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   io    : state_if slave (sw, close, floor in; dir, door out, both registered)
module state (
    input  logic   clk,
    input  logic   rst_n,
    state_if.slave io
);
    typedef enum logic [1:0] {IDLE = 2'd0, MOVING = 2'd1, OPEN = 2'd2} state_e;

    state_e     state_q, state_d;
    logic [7:0] req_q, req_d;
    logic [9:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic       door_q, door_d;

    logic [7:0] pend, kept, here, above, below;
    logic       ahead_p, ahead_k;

    always_comb begin
        // Calls take effect in the same cycle the switch is seen.
        pend    = req_q | io.sw;
        here    = 8'd1 << io.floor;
        kept    = pend & ~here;
        above   = ~((here << 1) - 8'd1);
        below   = here - 8'd1;
        ahead_p = dir_q ? |(pend & above) : |(pend & below);
        ahead_k = dir_q ? |(kept & above) : |(kept & below);
    end

    always_comb begin
        state_d = state_q;
        req_d   = pend;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        door_d  = door_q;
        case (state_q)
            IDLE: begin
                if (|(pend & here)) begin
                    state_d = OPEN;
                    door_d  = 1'b1;
                    cnt_d   = 10'd0;
                end else if (|pend) begin
                    state_d = MOVING;
                    dir_d   = ahead_p ? dir_q : ~dir_q;
                end
            end
            MOVING: begin
                if (|(pend & here)) begin
                    state_d = OPEN;
                    door_d  = 1'b1;
                    cnt_d   = 10'd0;
                    req_d   = kept;
                end else if (!ahead_p) begin
                    // Nothing ahead: turn around if anything is behind, else park.
                    if (|pend) dir_d = ~dir_q;
                    else state_d = IDLE;
                end
            end
            OPEN: begin
                req_d = kept;
                cnt_d = cnt_q + 10'd1;
                if (io.close || cnt_q == 10'h3ff) begin
                    door_d  = 1'b0;
                    cnt_d   = 10'd0;
                    state_d = |kept ? MOVING : IDLE;
                    dir_d   = (|kept && !ahead_k) ? ~dir_q : dir_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 8'd0;
            cnt_q   <= 10'd0;
            dir_q   <= 1'b1;
            door_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            door_q  <= door_d;
        end
    end

    assign io.dir  = dir_q;
    assign io.door = door_q;
endmodule

// File: tb/tb_state.sv
// tb_state: directed self-checking bench for the elevator controller.
module tb_state;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n;

    state_if io ();
    state dut (.clk(clk), .rst_n(rst_n), .io(io.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; io.sw = 8'h00; io.close = 1'b0; io.floor = 3'd0;
        tick(); tick();
        chk("rst_door", 32'(io.door), 0);
        chk("rst_dir", 32'(io.dir), 1);
        chk("rst_req", 32'(dut.req_q), 0);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("idle_hold_state", 32'(dut.state_q), 0);
        chk("idle_hold_door", 32'(io.door), 0);
        chk("idle_hold_dir", 32'(io.dir), 1);

        // Call floor 7 from floor 0
        io.sw = 8'h80; tick(); io.sw = 8'h00;
        chk("go7_state", 32'(dut.state_q), 1);
        chk("go7_dir", 32'(io.dir), 1);
        chk("go7_door", 32'(io.door), 0);
        io.close = 1'b1;
        repeat (10) tick();
        io.close = 1'b0;
        chk("close_ignored_state", 32'(dut.state_q), 1);
        chk("close_ignored_door", 32'(io.door), 0);
        io.floor = 3'd7; tick();
        chk("arrive7_door", 32'(io.door), 1);
        chk("arrive7_req", 32'(dut.req_q), 0);

        // Auto-close after 1024 cycles
        n = 1;
        io.sw = 8'h01; tick(); io.sw = 8'h00;
        while (io.door && n < 2000) begin
            n++;
            tick();
        end
        chk("dwell_cycles", 32'(n), 1024);
        chk("autoclose_state", 32'(dut.state_q), 1);
        chk("autoclose_dir", 32'(io.dir), 0);
        io.floor = 3'd0; tick();
        chk("arrive0_door", 32'(io.door), 1);

        // Exit OPEN at floor 0 with only a call above -> direction flips up
        io.sw = 8'h08; tick(); io.sw = 8'h00;
        chk("open0_req", 32'(dut.req_q), 32'h08);
        io.close = 1'b1; tick(); io.close = 1'b0;
        chk("flip_up_dir", 32'(io.dir), 1);
        chk("flip_up_state", 32'(dut.state_q), 1);
        io.floor = 3'd3; tick();
        chk("arrive3_door", 32'(io.door), 1);
        io.sw = 8'h20; tick(); io.sw = 8'h00;
        chk("open3_req", 32'(dut.req_q), 32'h20);
        io.close = 1'b1; tick(); io.close = 1'b0;
        chk("close3_door", 32'(io.door), 0);
        chk("close3_dir", 32'(io.dir), 1);
        chk("close3_state", 32'(dut.state_q), 1);
        io.floor = 3'd5; tick();
        chk("arrive5_door", 32'(io.door), 1);
        io.close = 1'b1; tick(); io.close = 1'b0;
        chk("park_state", 32'(dut.state_q), 0);
        chk("park_door", 32'(io.door), 0);

        // Current floor has priority over other calls
        io.floor = 3'd4; io.sw = 8'h11; tick(); io.sw = 8'h00;
        chk("serve4_door", 32'(io.door), 1);
        chk("serve4_state", 32'(dut.state_q), 2);
        tick();
        chk("serve4_req", 32'(dut.req_q), 32'h01);
        io.close = 1'b1; tick(); io.close = 1'b0;
        chk("leave4_state", 32'(dut.state_q), 1);
        chk("leave4_dir", 32'(io.dir), 0);
        io.floor = 3'd2; tick();
        chk("pass2_state", 32'(dut.state_q), 1);
        chk("pass2_door", 32'(io.door), 0);
        io.floor = 3'd0; tick();
        chk("stop0_door", 32'(io.door), 1);

        // Reset during OPEN overrides everything
        io.sw = 8'hff; tick();
        chk("open_req_ff", 32'(dut.req_q), 32'hfe);
        chk("open_dir_down", 32'(io.dir), 0);
        rst_n = 1'b0; io.close = 1'b1; tick();
        chk("midrst_door", 32'(io.door), 0);
        chk("midrst_dir", 32'(io.dir), 1);
        chk("midrst_req", 32'(dut.req_q), 0);
        chk("midrst_state", 32'(dut.state_q), 0);
        rst_n = 1'b1; io.sw = 8'h00; io.close = 1'b0;
        repeat (5) tick();
        chk("post_rst_state", 32'(dut.state_q), 0);
        chk("post_rst_door", 32'(io.door), 0);

        // Turn-around while moving, then stop at every pending floor
        io.floor = 3'd3; io.sw = 8'h20; tick(); io.sw = 8'h00;
        chk("up_from3_dir", 32'(io.dir), 1);
        io.sw = 8'h02; io.floor = 3'd6; tick(); io.sw = 8'h00;
        chk("turn_dir", 32'(io.dir), 0);
        chk("turn_state", 32'(dut.state_q), 1);
        io.floor = 3'd5; tick();
        chk("stop5_door", 32'(io.door), 1);
        io.close = 1'b1; tick(); io.close = 1'b0;
        chk("leave5_state", 32'(dut.state_q), 1);
        chk("leave5_dir", 32'(io.dir), 0);
        io.floor = 3'd1; tick();
        chk("stop1_door", 32'(io.door), 1);
        io.close = 1'b1; tick(); io.close = 1'b0;
        chk("final_state", 32'(dut.state_q), 0);
        chk("final_req", 32'(dut.req_q), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
